// File: rtl/thres_lane_resizer.sv
// Lane-count resizer behind the thresholding core: gathers narrow beats into
// wide ones, scatters wide beats into narrow ones, or passes lanes through
// unchanged. Lane 0 is always in the LSBs and channel order is preserved.
module thres_lane_resizer #(
   parameter int BITS   = 4,
   parameter int PE_IN  = 4,
   parameter int PE_OUT = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     irdy,
   input  logic                     ivld,
   input  logic [PE_IN*BITS-1:0]    idat,
   input  logic                     ordy,
   output logic                     ovld,
   output logic [PE_OUT*BITS-1:0]   odat
);
   localparam int IW = PE_IN * BITS;
   localparam int OW = PE_OUT * BITS;
   localparam int R  = (PE_IN > PE_OUT) ? PE_IN / PE_OUT : PE_OUT / PE_IN;
   localparam int CW = (R > 1) ? $clog2(R) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

   logic          ovld_q, ovld_d;
   logic [OW-1:0] odat_q, odat_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          irdy_c;
   logic          in_xfer;
   logic          out_xfer;

   assign irdy     = !rst && irdy_c;
   assign ovld     = ovld_q;
   assign odat     = odat_q;
   assign in_xfer  = irdy && ivld;
   assign out_xfer = ovld_q && ordy;

   generate
      if ((PE_IN % PE_OUT != 0) && (PE_OUT % PE_IN != 0)) begin : g_bad_ratio
         $error("thres_lane_resizer: PE_IN and PE_OUT must divide one another");
      end

      if (PE_IN == PE_OUT) begin : g_pass
         // Single output register, full throughput.
         always_comb begin
            irdy_c = !ovld_q || ordy;
            ovld_d = ovld_q;
            odat_d = odat_q;
            cnt_d  = '0;
            if (in_xfer) begin
               ovld_d = 1'b1;
               odat_d = idat;
            end else if (out_xfer) begin
               ovld_d = 1'b0;
            end
         end
      end else if (PE_OUT > PE_IN) begin : g_gather
         localparam int AW = (R - 1) * IW;
         logic [AW-1:0] a_q, a_d;

         // Partial beats go into the assembly register; the last beat of a
         // word is concatenated on top of it straight into the output register.
         always_comb begin
            irdy_c = (cnt_q != CNT_LAST) || !ovld_q || ordy;
            ovld_d = ovld_q;
            odat_d = odat_q;
            cnt_d  = cnt_q;
            a_d    = a_q;
            if (out_xfer) begin
               ovld_d = 1'b0;
            end
            if (in_xfer) begin
               if (cnt_q != CNT_LAST) begin
                  a_d[cnt_q*IW +: IW] = idat;
                  cnt_d               = cnt_q + 1'b1;
               end else begin
                  odat_d = {idat, a_q};
                  ovld_d = 1'b1;
                  cnt_d  = '0;
               end
            end
         end

         // Assembly register; cleared on reset so a partial word never leaks.
         always_ff @(posedge clk) begin
            if (rst) a_q <= '0;
            else     a_q <= a_d;
         end
      end else begin : g_scatter
         logic [IW-1:0] h_q, h_d;
         logic [CW-1:0] cnt_nx;

         // Hold the wide beat and step through its sub-words; a new beat can
         // load in the same cycle the last sub-word leaves, avoiding a bubble.
         always_comb begin
            irdy_c = !ovld_q || (ordy && (cnt_q == CNT_LAST));
            cnt_nx = cnt_q + 1'b1;
            ovld_d = ovld_q;
            odat_d = odat_q;
            cnt_d  = cnt_q;
            h_d    = h_q;
            if (in_xfer) begin
               h_d    = idat;
               odat_d = idat[OW-1:0];
               ovld_d = 1'b1;
               cnt_d  = '0;
            end else if (out_xfer) begin
               if (cnt_q != CNT_LAST) begin
                  cnt_d  = cnt_nx;
                  odat_d = h_q[cnt_nx*OW +: OW];
               end else begin
                  ovld_d = 1'b0;
                  cnt_d  = '0;
               end
            end
         end

         // Hold register for the wide beat being scattered.
         always_ff @(posedge clk) begin
            if (rst) h_q <= '0;
            else     h_q <= h_d;
         end
      end
   endgenerate

   // Output register and beat counter shared by all modes.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovld_q <= 1'b0;
         odat_q <= '0;
         cnt_q  <= '0;
      end else begin
         ovld_q <= ovld_d;
         odat_q <= odat_d;
         cnt_q  <= cnt_d;
      end
   end

   a_hold_stable: assert property (@(posedge clk) disable iff (rst)
      (ovld_q && !ordy) |=> (ovld_q && $stable(odat_q)));

   a_cnt_range: assert property (@(posedge clk) disable iff (rst)
      cnt_q <= CNT_LAST);
endmodule

// File: tb/tb_thres_lane_resizer.sv
// Bench for thres_lane_resizer: gather (2->4), scatter (4->2) and pass (4->4)
// instances checked against a lane-order queue model plus literal vectors.
module tb_thres_lane_resizer;
   logic clk = 1'b0;
   logic rst;

   logic        irdy_g, ivld_g, ordy_g, ovld_g;
   logic [7:0]  idat_g;
   logic [15:0] odat_g;
   logic        irdy_s, ivld_s, ordy_s, ovld_s;
   logic [15:0] idat_s;
   logic [7:0]  odat_s;
   logic        irdy_p, ivld_p, ordy_p, ovld_p;
   logic [15:0] idat_p;
   logic [15:0] odat_p;

   int n_checks = 0;
   int n_pass   = 0;

   logic [3:0]  q [3][$];
   int          acc [3];
   bit          stall [3];
   logic [15:0] held [3];

   thres_lane_resizer #(.BITS(4), .PE_IN(2), .PE_OUT(4)) u_gat (
      .clk(clk), .rst(rst), .irdy(irdy_g), .ivld(ivld_g), .idat(idat_g),
      .ordy(ordy_g), .ovld(ovld_g), .odat(odat_g));
   thres_lane_resizer #(.BITS(4), .PE_IN(4), .PE_OUT(2)) u_sca (
      .clk(clk), .rst(rst), .irdy(irdy_s), .ivld(ivld_s), .idat(idat_s),
      .ordy(ordy_s), .ovld(ovld_s), .odat(odat_s));
   thres_lane_resizer #(.BITS(4), .PE_IN(4), .PE_OUT(4)) u_pas (
      .clk(clk), .rst(rst), .irdy(irdy_p), .ivld(ivld_p), .idat(idat_p),
      .ordy(ordy_p), .ovld(ovld_p), .odat(odat_p));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drive(input int k, input logic v, input logic [15:0] d, input logic r);
      case (k)
         0:       begin ivld_g = v; idat_g = d[7:0]; ordy_g = r; end
         1:       begin ivld_s = v; idat_s = d;      ordy_s = r; end
         default: begin ivld_p = v; idat_p = d;      ordy_p = r; end
      endcase
   endtask

   function automatic logic get_irdy(input int k);
      case (k)
         0:       return irdy_g;
         1:       return irdy_s;
         default: return irdy_p;
      endcase
   endfunction

   function automatic logic get_ovld(input int k);
      case (k)
         0:       return ovld_g;
         1:       return ovld_s;
         default: return ovld_p;
      endcase
   endfunction

   function automatic logic [15:0] get_odat(input int k);
      case (k)
         0:       return odat_g;
         1:       return {8'h00, odat_s};
         default: return odat_p;
      endcase
   endfunction

   function automatic int pe_out_of(input int k);
      return (k == 1) ? 2 : 4;
   endfunction

   // Lane-order model: every accepted input lane is queued; every output
   // transfer must carry the oldest PE_OUT queued lanes, lane 0 in the LSBs.
   task automatic mon(input int k, input logic ir, input logic iv, input logic [15:0] id,
                      input int pin, input logic orr, input logic ov, input logic [15:0] od,
                      input int pout);
      logic [15:0] e;
      if (rst) begin
         q[k].delete();
         stall[k] = 1'b0;
         return;
      end
      if (stall[k]) chk($sformatf("hold%0d", k), {15'h0, ov, od}, {15'h0, 1'b1, held[k]});
      if (ov && orr) begin
         if (q[k].size() < pout) begin
            chk($sformatf("underflow%0d", k), q[k].size(), pout);
         end else begin
            e = '0;
            for (int j = 0; j < pout; j++) e[4*j +: 4] = q[k].pop_front();
            chk($sformatf("lanes%0d", k), od, e);
         end
      end
      if (ir && iv) begin
         for (int i = 0; i < pin; i++) q[k].push_back(id[4*i +: 4]);
         acc[k] += pin;
      end
      stall[k] = ov && !orr;
      held[k]  = od;
   endtask

   // Single compare process for all three instances.
   always @(negedge clk) begin
      mon(0, irdy_g, ivld_g, {8'h00, idat_g}, 2, ordy_g, ovld_g, odat_g, 4);
      mon(1, irdy_s, ivld_s, idat_s, 4, ordy_s, ovld_s, {8'h00, odat_s}, 2);
      mon(2, irdy_p, ivld_p, idat_p, 4, ordy_p, ovld_p, odat_p, 4);
   end

   task automatic soak(input int k);
      int cyc  = 0;
      int base = acc[k];
      int ph;
      logic v, r;
      while ((acc[k] - base) < 10000 && cyc < 30000) begin
         step();
         ph = cyc % 400;
         v  = (ph >= 360) ? 1'b1 : ($urandom_range(0, 99) < 70);
         r  = (ph >= 360) ? 1'b1 : ($urandom_range(0, 99) < 70);
         drive(k, v, 16'($urandom), r);
         if (ph >= 366) begin
            smp();
            if (k != 1) chk($sformatf("burst_irdy%0d", k), get_irdy(k), 1);
            if (k != 0) chk($sformatf("burst_ovld%0d", k), get_ovld(k), 1);
         end
         cyc++;
      end
      if ((acc[k] - base) < 10000) chk($sformatf("soak_budget%0d", k), acc[k] - base, 10000);
      step();
      drive(k, 1'b0, 16'h0, 1'b1);
      repeat (20) step();
      smp();
      chk($sformatf("drain_ovld%0d", k), get_ovld(k), 0);
      chk($sformatf("drain_resid%0d", k), q[k].size() < pe_out_of(k), 1);
   endtask

   initial begin
      rst = 1'b1;
      ivld_g = 1'b1; idat_g = 8'hFF;    ordy_g = 1'b1;
      ivld_s = 1'b1; idat_s = 16'hFFFF; ordy_s = 1'b1;
      ivld_p = 1'b1; idat_p = 16'hFFFF; ordy_p = 1'b1;
      repeat (3) begin
         smp();
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_irdy%0d", k), get_irdy(k), 0);
            chk($sformatf("rst_ovld%0d", k), get_ovld(k), 0);
            chk($sformatf("rst_odat%0d", k), get_odat(k), 0);
         end
      end
      step();
      rst = 1'b0;
      ivld_s = 1'b0; ivld_p = 1'b0;
      idat_g = 8'h21;
      smp();
      for (int k = 0; k < 3; k++) chk($sformatf("rel_irdy%0d", k), get_irdy(k), 1);

      // gather, ordy high
      step(); idat_g = 8'h43; smp(); chk("g_ovld_a", ovld_g, 0);
      step(); idat_g = 8'h65; smp();
      chk("g_odat_4321", odat_g, 16'h4321); chk("g_ovld_b", ovld_g, 1); chk("g_irdy_b", irdy_g, 1);
      step(); idat_g = 8'h87; smp(); chk("g_ovld_c", ovld_g, 0); chk("g_irdy_c", irdy_g, 1);
      step(); ivld_g = 1'b0; smp(); chk("g_odat_8765", odat_g, 16'h8765); chk("g_ovld_d", ovld_g, 1);

      // gather back-pressure
      step(); ivld_g = 1'b1; idat_g = 8'h21; ordy_g = 1'b0; smp(); chk("gb_ovld0", ovld_g, 0);
      step(); idat_g = 8'h43; smp();
      step(); idat_g = 8'h65; smp();
      chk("gb_odat_a", odat_g, 16'h4321); chk("gb_irdy_a", irdy_g, 1);
      step(); idat_g = 8'h87; smp(); chk("gb_irdy_stall", irdy_g, 0); chk("gb_odat_b", odat_g, 16'h4321);
      step(); smp(); chk("gb_irdy_stall2", irdy_g, 0);
      step(); ordy_g = 1'b1; smp(); chk("gb_irdy_go", irdy_g, 1); chk("gb_odat_c", odat_g, 16'h4321);
      step(); ivld_g = 1'b0; smp(); chk("gb_odat_8765", odat_g, 16'h8765); chk("gb_ovld", ovld_g, 1);
      step(); smp(); chk("gb_ovld_end", ovld_g, 0);

      // reset in the middle of a gather
      step(); ivld_g = 1'b1; idat_g = 8'h21; smp();
      step(); ivld_g = 1'b0; rst = 1'b1; smp(); chk("gr_irdy_rst", irdy_g, 0);
      step(); rst = 1'b0; ivld_g = 1'b1; idat_g = 8'hBA; smp(); chk("gr_ovld0", ovld_g, 0);
      step(); idat_g = 8'hDC; smp(); chk("gr_ovld1", ovld_g, 0);
      step(); ivld_g = 1'b0; smp(); chk("gr_odat_dcba", odat_g, 16'hDCBA); chk("gr_ovld2", ovld_g, 1);
      step(); smp();

      // scatter, ordy high
      step(); ivld_s = 1'b1; idat_s = 16'h4321; ordy_s = 1'b1; smp(); chk("s_irdy0", irdy_s, 1);
      step(); idat_s = 16'h8765; smp();
      chk("s_odat_21", odat_s, 8'h21); chk("s_ovld", ovld_s, 1); chk("s_irdy_a", irdy_s, 0);
      step(); smp(); chk("s_odat_43", odat_s, 8'h43); chk("s_irdy_b", irdy_s, 1);
      step(); ivld_s = 1'b0; smp(); chk("s_odat_65", odat_s, 8'h65); chk("s_irdy_c", irdy_s, 0);
      step(); smp(); chk("s_odat_87", odat_s, 8'h87); chk("s_irdy_d", irdy_s, 1);
      step(); smp(); chk("s_ovld_end", ovld_s, 0);

      // scatter stall while 0x43 is shown
      step(); ivld_s = 1'b1; idat_s = 16'h4321; smp();
      step(); idat_s = 16'h8765; smp(); chk("ss_odat_21", odat_s, 8'h21);
      step(); ordy_s = 1'b0; smp(); chk("ss_odat_43", odat_s, 8'h43);
      repeat (5) begin
         step(); smp();
         chk("ss_hold_43", odat_s, 8'h43); chk("ss_irdy_stall", irdy_s, 0);
      end
      step(); ordy_s = 1'b1; smp(); chk("ss_odat_43b", odat_s, 8'h43); chk("ss_irdy_go", irdy_s, 1);
      step(); ivld_s = 1'b0; smp(); chk("ss_odat_65", odat_s, 8'h65);
      step(); smp(); chk("ss_odat_87", odat_s, 8'h87);
      step(); smp(); chk("ss_ovld_end", ovld_s, 0);

      // pass-through latency
      step(); ivld_p = 1'b1; idat_p = 16'hA5C3; ordy_p = 1'b1; smp(); chk("p_ovld0", ovld_p, 0);
      step(); ivld_p = 1'b0; smp(); chk("p_odat", odat_p, 16'hA5C3); chk("p_ovld1", ovld_p, 1);
      step(); smp(); chk("p_ovld_end", ovld_p, 0);

      fork
         soak(0);
         soak(1);
         soak(2);
      join

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
